// File: rtl/elastic_pipeline.sv
// Elastic delay line: STAGES registers with a valid bit per stage, bubble-collapsing
// valid/ready handshake, synchronous flush and a registered occupancy count.
module elastic_pipeline #(
   parameter int STAGES     = 4,
   parameter int DATA_WIDTH = 32
) (
   input  logic                        clk_in,
   input  logic                        rst_n_in,
   input  logic                        flush_in,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [DATA_WIDTH-1:0]       in_data,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [DATA_WIDTH-1:0]       out_data,
   output logic [$clog2(STAGES+1)-1:0] occupancy
);
   localparam int OCC_W = $clog2(STAGES+1);

   logic [STAGES-1:0]     v_q, v_d;
   logic [STAGES-1:0]     adv, load;
   logic [DATA_WIDTH-1:0] d_q [STAGES];
   logic [DATA_WIDTH-1:0] d_d [STAGES];
   logic [OCC_W-1:0]      occ_q, occ_d;
   logic                  accept;

   // Advance ripples back from the drain; ready to the input is combinational from out_ready.
   always_comb begin
      adv = '0;
      adv[STAGES-1] = v_q[STAGES-1] & out_ready;
      for (int i = STAGES-2; i >= 0; i--) begin
         adv[i] = v_q[i] & (~v_q[i+1] | adv[i+1]);
      end
      load = ~v_q | adv;
   end

   assign in_ready = load[0] & ~flush_in;
   assign accept   = in_valid & in_ready;

   always_comb begin
      v_d = v_q;
      for (int i = 0; i < STAGES; i++) begin
         d_d[i] = d_q[i];
      end
      if (flush_in) begin
         v_d = '0;
      end else begin
         if (load[0]) begin
            v_d[0] = accept;
            if (accept) begin
               d_d[0] = in_data;
            end
         end
         for (int i = 1; i < STAGES; i++) begin
            if (load[i]) begin
               v_d[i] = adv[i-1];
            end
            if (adv[i-1]) begin
               d_d[i] = d_q[i-1];
            end
         end
      end
      occ_d = '0;
      for (int i = 0; i < STAGES; i++) begin
         occ_d = occ_d + OCC_W'(v_d[i]);
      end
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         v_q   <= '0;
         occ_q <= '0;
         for (int i = 0; i < STAGES; i++) begin
            d_q[i] <= '0;
         end
      end else begin
         v_q   <= v_d;
         occ_q <= occ_d;
         for (int i = 0; i < STAGES; i++) begin
            d_q[i] <= d_d[i];
         end
      end
   end

   assign out_valid = v_q[STAGES-1];
   assign out_data  = d_q[STAGES-1];
   assign occupancy = occ_q;
endmodule

// File: tb/tb_elastic_pipeline.sv
// Bench for elastic_pipeline: directed scenarios on a 4-stage line, then random
// valid/ready/flush on 4-, 1- and 5-stage lines checked by per-instance scoreboards.
module tb_elastic_pipeline;
   logic clk = 1'b0;
   logic rst_n;
   logic [2:0]       iv, ir, ov, orr, fl;
   logic [2:0][31:0] id, od;
   logic [2:0][3:0]  occ;
   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   task automatic chk(input string nm, input longint unsigned act, input longint unsigned exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   for (genvar g = 0; g < 3; g++) begin : g_inst
      localparam int S  = (g == 0) ? 4 : ((g == 1) ? 1 : 5);
      localparam int OW = $clog2(S+1);
      logic [OW-1:0] occ_w;

      elastic_pipeline #(.STAGES(S), .DATA_WIDTH(32)) u_dut (
         .clk_in    (clk),
         .rst_n_in  (rst_n),
         .flush_in  (fl[g]),
         .in_valid  (iv[g]),
         .in_ready  (ir[g]),
         .in_data   (id[g]),
         .out_valid (ov[g]),
         .out_ready (orr[g]),
         .out_data  (od[g]),
         .occupancy (occ_w)
      );
      assign occ[g] = 4'(occ_w);

      // Reference: a FIFO of accepted beats with their accept time; depth is the occupancy.
      int unsigned q_d[$];
      int          q_t[$];
      int          ncyc = 0;
      logic        last_stall = 1'b0;
      logic [31:0] last_d;

      always @(negedge clk) begin
         ncyc++;
         if (!rst_n) begin
            q_d.delete();
            q_t.delete();
            last_stall = 1'b0;
         end else begin
            chk($sformatf("u%0d_occ", g), occ[g], q_d.size());
            chk($sformatf("u%0d_in_ready", g), ir[g],
                (!fl[g] && ((q_d.size() < S) || orr[g])) ? 1 : 0);
            if (q_d.size() == 0) begin
               chk($sformatf("u%0d_out_valid_empty", g), ov[g], 0);
            end else if (ov[g]) begin
               chk($sformatf("u%0d_out_data", g), od[g], q_d[0]);
            end
            if (last_stall) begin
               chk($sformatf("u%0d_hold_valid", g), ov[g], 1);
               chk($sformatf("u%0d_hold_data", g), od[g], last_d);
            end
            last_stall = ov[g] & ~orr[g] & ~fl[g];
            last_d     = od[g];
            if (ov[g] && orr[g] && q_d.size() > 0) begin
               chk($sformatf("u%0d_min_latency", g), (ncyc - q_t[0] >= S) ? 1 : 0, 1);
               void'(q_d.pop_front());
               void'(q_t.pop_front());
            end
            if (fl[g]) begin
               q_d.delete();
               q_t.delete();
            end else if (iv[g] && ir[g]) begin
               q_d.push_back(id[g]);
               q_t.push_back(ncyc);
            end
         end
      end
   end

   initial begin
      int pv, pr;
      rst_n = 1'b0;
      iv = '0; orr = '0; fl = '0; id = '0;
      #2;
      chk("rst_out_valid", ov[0], 0);
      chk("rst_out_data", od[0], 0);
      chk("rst_occupancy", occ[0], 0);
      chk("rst_in_ready", ir[0], 1);
      tick();
      rst_n = 1'b1;

      // streaming, 4 stages
      iv[0] = 1'b1; orr[0] = 1'b1; id[0] = 32'd1;
      for (int k = 1; k <= 10; k++) begin
         tick();
         chk("stream_out_valid", ov[0], (k >= 4) ? 1 : 0);
         if (k >= 4) chk("stream_out_data", od[0], k - 3);
         chk("stream_occ", occ[0], (k < 4) ? k : 4);
         id[0] = 32'(k + 1);
      end
      iv[0] = 1'b0;
      repeat (4) tick();
      chk("stream_drained", occ[0], 0);

      // bubble collapse
      orr[0] = 1'b0;
      iv[0] = 1'b1; id[0] = 32'hA;
      tick();
      iv[0] = 1'b0;
      repeat (2) tick();
      iv[0] = 1'b1; id[0] = 32'hB;
      tick();
      iv[0] = 1'b0;
      repeat (4) tick();
      chk("bubble_occ", occ[0], 2);
      chk("bubble_out_valid", ov[0], 1);
      chk("bubble_out_data", od[0], 32'hA);
      chk("bubble_in_ready", ir[0], 1);
      orr[0] = 1'b1;
      repeat (4) tick();
      chk("bubble_drained", occ[0], 0);

      // full back-pressure
      orr[0] = 1'b0; iv[0] = 1'b1;
      for (int n = 1; n <= 4; n++) begin
         id[0] = 32'h100 + 32'(n);
         tick();
      end
      id[0] = 32'h105;
      chk("full_in_ready", ir[0], 0);
      chk("full_occ", occ[0], 4);
      repeat (2) tick();
      chk("full_hold_in_ready", ir[0], 0);
      chk("full_hold_data", od[0], 32'h101);
      orr[0] = 1'b1;
      #1;
      chk("full_ready_from_drain", ir[0], 1);
      tick();
      iv[0] = 1'b0;
      chk("full_swap_occ", occ[0], 4);
      chk("full_swap_data", od[0], 32'h102);
      repeat (4) tick();
      chk("full_drained", occ[0], 0);

      // flush
      orr[0] = 1'b0; iv[0] = 1'b1;
      for (int n = 1; n <= 3; n++) begin
         id[0] = 32'h200 + 32'(n);
         tick();
      end
      chk("flush_pre_occ", occ[0], 3);
      fl[0] = 1'b1; id[0] = 32'h2FF;
      #1;
      chk("flush_in_ready", ir[0], 0);
      tick();
      chk("flush_occ", occ[0], 0);
      chk("flush_out_valid", ov[0], 0);
      fl[0] = 1'b0; iv[0] = 1'b0;
      #1;
      chk("flush_ready_after", ir[0], 1);
      tick();
      chk("flush_not_captured", occ[0], 0);

      // asynchronous reset mid-stream
      iv[0] = 1'b1;
      for (int n = 1; n <= 3; n++) begin
         id[0] = 32'h300 + 32'(n);
         tick();
      end
      iv[0] = 1'b0;
      tick();
      chk("arst_pre_occ", occ[0], 3);
      chk("arst_pre_valid", ov[0], 1);
      chk("arst_pre_data", od[0], 32'h301);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_out_valid", ov[0], 0);
      chk("arst_out_data", od[0], 0);
      chk("arst_occ", occ[0], 0);
      chk("arst_in_ready", ir[0], 1);
      repeat (2) tick();
      rst_n = 1'b1;

      // random traffic on all three lines
      pv = 50; pr = 50;
      for (int c = 0; c < 10000; c++) begin
         if (c % 500 == 0) begin
            pv = $urandom_range(100, 20);
            pr = $urandom_range(100, 10);
         end
         for (int g = 0; g < 3; g++) begin
            iv[g]  = ($urandom_range(99) < pv);
            orr[g] = ($urandom_range(99) < pr);
            fl[g]  = ($urandom_range(63) == 0);
            id[g]  = $urandom;
         end
         tick();
      end
      iv = '0; fl = '0; orr = 3'b111;
      repeat (8) tick();
      for (int g = 0; g < 3; g++) begin
         chk($sformatf("u%0d_final_occ", g), occ[g], 0);
         chk($sformatf("u%0d_final_valid", g), ov[g], 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/elastic_pipeline.md
Name: elastic_pipeline

Overview:
- Parametrised successor to the fixed shift-register and freezable delay lines.
- A STAGES-deep, DATA_WIDTH-wide delay line with a valid/ready handshake on each end and a valid bit per stage.
- Bubbles collapse: a stage advances whenever the stage after it is empty or is itself advancing. Back-pressure therefore stalls only the occupied tail, not the whole line.
- Adds synchronous flush and an occupancy count. Used between rasteriser/projection stages that have variable downstream acceptance.

Parameters:
- STAGES, 4, number of register stages (>=1); latency in cycles when unstalled.
- DATA_WIDTH, 32, payload width in bits.

Ports:
- clk_in  input  1  system clock; all state updates on rising edge.
- rst_n_in  input  1  asynchronous, active-low reset.
- flush_in  input  1  synchronous clear of all stage valids.
- in_valid  input  1  upstream presents in_data.
- in_ready  output  1  pipeline can accept in_data this cycle.
- in_data  input  DATA_WIDTH  payload.
- out_valid  output  1  stage STAGES-1 holds valid data.
- out_ready  input  1  downstream accepts out_data this cycle.
- out_data  output  DATA_WIDTH  payload of final stage.
- occupancy  output  $clog2(STAGES+1)  number of valid stages.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low. Clock is clk_in, reset is rst_n_in.
- Reset (rst_n_in=0, asynchronous): all stage valids=0 and all stage data=0. Outputs: out_valid=0, out_data=0, occupancy=0, in_ready=1 (flush_in low). Asserting reset mid-stream discards all contents immediately, with no partial drain.
- State: per stage i, a valid bit v[i] and a data register d[i].
- Advance terms (combinational):
  - adv[STAGES-1] = v[STAGES-1] & out_ready (drain).
  - For i<STAGES-1: adv[i] = v[i] & (!v[i+1] | adv[i+1]).
  - A stage loads when empty or advancing: load[i] = !v[i] | adv[i]. load[i] is also the accept signal for stage i-1 (or the input).
- in_ready = (!v[0] | adv[0]) & !flush_in. It is combinational from out_ready through the valid chain. This ready path is intentional; insert a skid buffer externally if timing requires.
- Input accept: occurs when in_valid & in_ready.
- Register updates on the clock edge, when flush_in=0:
  - Stage 0: if load[0], v[0] <= accept, and d[0] <= in_data only on accept (d holds otherwise).
  - Stage i>0: if load[i], v[i] <= adv[i-1]; d[i] <= d[i-1] when adv[i-1].
  - Non-loading stages hold both v and d.
- Flush: flush_in=1 clears all v[] at the next edge. The input is not accepted that cycle (in_ready=0). An output transfer on the same cycle (out_valid & out_ready) still completes, since data is already presented. d[] is not cleared.
- Latency: STAGES cycles from input accept to out_valid with out_ready held high. Throughput is 1 beat/cycle.
- Ordering: strict FIFO. No beat is ever dropped or duplicated except by flush or reset.
- Full: all v=1 and out_ready=0 gives in_ready=0. A simultaneous drain and accept when full is legal; occupancy stays at STAGES.
- Stall with a partial fill: the front stages keep advancing until they abut the stalled tail (bubble collapse).
- occupancy: registered popcount of v[]. It updates in the same edge as v[] and is always consistent with v[]. Maximum value STAGES, no wrap.
- out_data is stable while out_valid=1 & out_ready=0 (AXI-style hold).
- STAGES=1: degenerates to a single register with in_ready = !v[0] | out_ready.

Test Plan:
- Streaming: STAGES=4, out_ready=1, in_valid=1, data 1,2,3,... -> first out_valid at cycle 4 after first accept, data 1,2,3 in order, one per cycle, occupancy=4 steady.
- Bubble collapse: send beats A,B separated by 2 idle cycles, out_ready=0 -> B lands in stage 2 adjacent to A in stage 3, occupancy=2, in_ready stays 1.
- Full back-pressure: out_ready=0, push 5 beats -> in_ready=0 after 4th accept, 5th held upstream. Raise out_ready -> 5th accepted in the same cycle stage 3 drains, occupancy remains 4.
- Flush: fill 3 beats, assert flush_in one cycle with in_valid=1 -> in_ready=0 that cycle, next cycle occupancy=0, out_valid=0, flushed input not captured.
- Async reset mid-stream: drop rst_n_in between clock edges while occupancy=3 -> out_valid, out_data, occupancy go to 0 without a clock edge, and in_ready=1.
- Random valid/ready (10k cycles, STAGES=1 and 5) -> scoreboard shows exact in-order delivery, out_data stable under stall, occupancy equals accepts minus drains.
